// File: rtl/data_segment_pkg.sv
// Frame geometry and select-state types shared by the lane segmenter and merger.
// Keeps both ends of a lane agreed on samples per frame and first-segment length.
package data_segment_pkg;

  localparam int DEF_DATA_W    = 76;     // {tag, real, imag}
  localparam int LANE_MAX_CNT  = 31250;
  localparam int LANE_SKIP_CNT = 5000;

  typedef enum logic {
    SEL_FIRST = 1'b0,
    SEL_MAIN  = 1'b1
  } seg_sel_t;

  function automatic int cnt_w(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/data_segment_merge_axis_out_reg.sv
// Purpose: single-entry valid/ready output register (data + last).
// Latency: 1 cycle from input accept to out_vld.
// Backpressure: in_rdy = !out_vld | out_rdy, so one beat/cycle; output held stable while stalled.
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  input  logic         in_last,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_last
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat  <= in_dat;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/data_segment_merge.sv
// Purpose: re-joins first (SKIP_CNT) and main (MAX_CNT-SKIP_CNT) segments into one tlast-framed stream.
// Latency: 1 cycle accept-to-output. Backpressure: selected input ready = !m_axis_tvalid | m_axis_tready; other input held off.
// Optional DATA_SEGMENT_MERGE_CHK_EN: sticky seg_err when an input tlast disagrees with the beat count.
module data_segment_merge
  import data_segment_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_CNT  = LANE_MAX_CNT,
  parameter int SKIP_CNT = LANE_SKIP_CNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_first_axis_tdata,
  input  logic              s_first_axis_tvalid,
  input  logic              s_first_axis_tlast,
  output logic              s_first_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              frame_done,
  output logic              seg_err
);

  localparam int CW = cnt_w(MAX_CNT);
  localparam logic [CW-1:0] SKIP_LAST  = CW'(SKIP_CNT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(MAX_CNT - 1);

  if (SKIP_CNT < 1 || SKIP_CNT > MAX_CNT - 1) begin : g_bad_geom
    $error("data_segment_merge: SKIP_CNT must be in 1..MAX_CNT-1");
  end

  seg_sel_t          state;
  logic [CW-1:0]     cnt;
  logic              sel_vld;
  logic              sel_rdy;
  logic              acc;
  logic              beat_last;
  logic [DATA_W-1:0] sel_dat;

  assign sel_vld   = (state == SEL_FIRST) ? s_first_axis_tvalid : s_axis_tvalid;
  assign sel_dat   = (state == SEL_FIRST) ? s_first_axis_tdata  : s_axis_tdata;
  assign beat_last = (cnt == FRAME_LAST);
  assign acc       = sel_vld && sel_rdy && !rst;

  assign s_first_axis_tready = !rst && (state == SEL_FIRST) && sel_rdy;
  assign s_axis_tready       = !rst && (state == SEL_MAIN)  && sel_rdy;

  axis_out_reg #(.W(DATA_W)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (sel_vld),
    .in_rdy   (sel_rdy),
    .in_dat   (sel_dat),
    .in_last  (beat_last),
    .out_vld  (m_axis_tvalid),
    .out_rdy  (m_axis_tready),
    .out_dat  (m_axis_tdata),
    .out_last (m_axis_tlast)
  );

  // cnt spans the whole frame; the state only decides which input feeds it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEL_FIRST;
      cnt   <= '0;
    end else if (acc) begin
      if (beat_last) begin
        state <= SEL_FIRST;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == SEL_FIRST && cnt == SKIP_LAST) state <= SEL_MAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
  end

`ifdef DATA_SEGMENT_MERGE_CHK_EN
  logic tlast_in;
  logic tlast_exp;

  assign tlast_in  = (state == SEL_FIRST) ? s_first_axis_tlast : s_axis_tlast;
  assign tlast_exp = (state == SEL_FIRST) ? (cnt == SKIP_LAST) : beat_last;

  always_ff @(posedge clk) begin
    if (rst)                             seg_err <= 1'b0;
    else if (acc && tlast_in != tlast_exp) seg_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_first_axis_tlast ^ s_axis_tlast;
  assign seg_err      = 1'b0;
`endif

endmodule

// File: tb/tb_data_segment_merge.sv
// Randomized bench for data_segment_merge: small-geometry instance against a frame-arithmetic model,
// plus one default-geometry instance streamed for a full frame.
module tb_data_segment_merge;

  localparam int DW = 32;
  localparam int M  = 8;
  localparam int S  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] s_first_axis_tdata, s_axis_tdata, m_axis_tdata;
  logic          s_first_axis_tvalid, s_first_axis_tlast, s_first_axis_tready;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          frame_done, seg_err;

  data_segment_merge #(.DATA_W(DW), .MAX_CNT(M), .SKIP_CNT(S)) dut (
    .clk(clk), .rst(rst),
    .s_first_axis_tdata(s_first_axis_tdata), .s_first_axis_tvalid(s_first_axis_tvalid),
    .s_first_axis_tlast(s_first_axis_tlast), .s_first_axis_tready(s_first_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .frame_done(frame_done), .seg_err(seg_err)
  );

  // default-geometry instance
  logic        rst2;
  logic [75:0] f2_dat, m2_dat, o2_dat;
  logic        f2_vld, f2_last, f2_rdy, m2_vld, m2_last, m2_rdy;
  logic        o2_vld, o2_last, o2_rdy, fd2_sig, seg2;
  logic        done2 = 1'b0;

  data_segment_merge dut2 (
    .clk(clk), .rst(rst2),
    .s_first_axis_tdata(f2_dat), .s_first_axis_tvalid(f2_vld),
    .s_first_axis_tlast(f2_last), .s_first_axis_tready(f2_rdy),
    .s_axis_tdata(m2_dat), .s_axis_tvalid(m2_vld),
    .s_axis_tlast(m2_last), .s_axis_tready(m2_rdy),
    .m_axis_tdata(o2_dat), .m_axis_tvalid(o2_vld),
    .m_axis_tlast(o2_last), .m_axis_tready(o2_rdy),
    .frame_done(fd2_sig), .seg_err(seg2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state: generated sample sequences per source, beat counters
  logic [DW-1:0] first_seq[$];
  logic [DW-1:0] main_seq[$];
  int   in_cnt, out_idx, cyc;
  int   p_first, p_main, rdy_mode;
  logic exp_vld, exp_fd, exp_err, f_held, m_held, inject;

  // output beat k of the merged stream, derived from frame geometry alone
  function automatic logic [DW-1:0] exp_dat(input int k);
    int fr;
    int pos;
    fr  = k / M;
    pos = k % M;
    if (pos < S) return first_seq[fr*S + pos];
    return main_seq[fr*(M-S) + pos - S];
  endfunction

  task automatic step();
    int   pos;
    logic f_rdy_e, s_rdy_e, f_hs, m_hs, o_hs;
    @(negedge clk);
    chk("m_vld", m_axis_tvalid, exp_vld);
    if (exp_vld) begin
      chk("m_dat", m_axis_tdata, exp_dat(out_idx));
      chk("m_last", m_axis_tlast, (out_idx % M) == M-1);
    end
    chk("frame_done", frame_done, exp_fd);
    chk("seg_err", seg_err, exp_err);

    if (!f_held) begin
      s_first_axis_tvalid = ($urandom_range(99) < p_first);
      if (s_first_axis_tvalid) begin
        s_first_axis_tdata = $urandom;
        first_seq.push_back(s_first_axis_tdata);
        s_first_axis_tlast = ((first_seq.size()-1) % S) == S-1;
        if (inject && ((first_seq.size()-1) % S) == 1) begin
          s_first_axis_tlast = 1'b1;
          inject = 1'b0;
        end
      end
    end
    if (!m_held) begin
      s_axis_tvalid = ($urandom_range(99) < p_main);
      if (s_axis_tvalid) begin
        s_axis_tdata = $urandom;
        main_seq.push_back(s_axis_tdata);
        s_axis_tlast = ((main_seq.size()-1) % (M-S)) == M-S-1;
      end
    end
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_axis_tready = ($urandom_range(99) < 70);
    endcase
    cyc++;

    #1;
    pos     = in_cnt % M;
    f_rdy_e = (pos < S)  && (!exp_vld || m_axis_tready);
    s_rdy_e = (pos >= S) && (!exp_vld || m_axis_tready);
    chk("f_rdy", s_first_axis_tready, f_rdy_e);
    chk("s_rdy", s_axis_tready, s_rdy_e);
    f_hs = s_first_axis_tvalid && f_rdy_e;
    m_hs = s_axis_tvalid && s_rdy_e;
    o_hs = exp_vld && m_axis_tready;
`ifdef DATA_SEGMENT_MERGE_CHK_EN
    if (f_hs && s_first_axis_tlast != (pos == S-1)) exp_err = 1'b1;
    if (m_hs && s_axis_tlast != (pos == M-1))       exp_err = 1'b1;
`endif
    exp_fd = o_hs && (out_idx % M) == M-1;
    if (o_hs) out_idx++;
    if (f_hs || m_hs) in_cnt++;
    exp_vld = f_hs || m_hs || (exp_vld && !m_axis_tready);
    f_held  = s_first_axis_tvalid && !f_hs;
    m_held  = s_axis_tvalid && !m_hs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_first_axis_tvalid = 1'b0;
    s_axis_tvalid = 1'b0;
    f_held = 1'b0;
    m_held = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_f_rdy", s_first_axis_tready, 1'b0);
    chk("rst_s_rdy", s_axis_tready, 1'b0);
    chk("rst_m_vld", m_axis_tvalid, 1'b0);
    chk("rst_m_last", m_axis_tlast, 1'b0);
    chk("rst_m_dat", m_axis_tdata, '0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_seg_err", seg_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    first_seq.delete();
    main_seq.delete();
    in_cnt = 0; out_idx = 0;
    exp_vld = 1'b0; exp_fd = 1'b0; exp_err = 1'b0; inject = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_first_axis_tdata = '0; s_first_axis_tvalid = 1'b0; s_first_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    cyc = 0; p_first = 0; p_main = 0; rdy_mode = 0;
    do_reset();

    // streaming, both inputs always valid
    p_first = 100; p_main = 100; rdy_mode = 0;
    repeat (3*M + 4) step();
    // downstream ready pattern 1,0,0,1
    rdy_mode = 1;
    repeat (9*M) step();

    // main valid early, first held off for 10 cycles
    do_reset();
    p_first = 0; p_main = 100; rdy_mode = 0;
    repeat (10) step();
    p_first = 100;
    repeat (2*M) step();

    // random valids and backpressure
    p_first = 70; p_main = 70; rdy_mode = 2;
    repeat (300) step();

    // reset after 5 beats of a frame have left
    p_first = 100; p_main = 100; rdy_mode = 0;
    for (int i = 0; i < 50 && (out_idx % M) != 5; i++) step();
    chk("midrst_pos", out_idx % M, 5);
    do_reset();
    repeat (2*M + 4) step();

    // early tlast on first-segment beat 1 of 0..2
    inject = 1'b1;
    repeat (3*M) step();
`ifdef DATA_SEGMENT_MERGE_CHK_EN
    chk("seg_err_sticky", seg_err, 1'b1);
`else
    chk("seg_err_off", seg_err, 1'b0);
`endif

    while (!done2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // full default frame: first source sends 0..4999, main sends 0x100000+i
  initial begin
    int f2c, m2c, o2c, fd2, n_last, last_pos, sw, bad;
    logic [75:0] e2;
    f2c = 0; m2c = 0; o2c = 0; fd2 = 0; n_last = 0; last_pos = -1; sw = -1; bad = 0;
    rst2 = 1'b1; f2_vld = 1'b0; m2_vld = 1'b0; o2_rdy = 1'b1;
    f2_dat = '0; m2_dat = '0; f2_last = 1'b0; m2_last = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c < 31300; c++) begin
      @(negedge clk);
      if (fd2_sig) fd2++;
      if (o2_vld) begin
        e2 = (o2c < 5000) ? 76'(o2c) : 76'(32'h100000 + o2c - 5000);
        if (o2_dat !== e2) bad++;
        if (o2_last) begin
          n_last++;
          last_pos = o2c;
        end
        o2c++;
      end
      f2_vld = (f2c < 5000);  f2_dat = 76'(f2c);              f2_last = (f2c == 4999);
      m2_vld = (m2c < 26250); m2_dat = 76'(32'h100000 + m2c); m2_last = (m2c == 26249);
      #1;
      if (m2_rdy && sw < 0) sw = f2c;
      if (f2_vld && f2_rdy) f2c++;
      if (m2_vld && m2_rdy) m2c++;
    end
    chk("dflt_beats", o2c, 31250);
    chk("dflt_last_pos", last_pos, 31249);
    chk("dflt_n_last", n_last, 1);
    chk("dflt_switch", sw, 5000);
    chk("dflt_frame_done", fd2, 1);
    chk("dflt_data_bad", bad, 0);
    chk("dflt_seg_err", seg2, 1'b0);
    done2 = 1'b1;
  end

endmodule
